bus_arbiter8: RTL and testbench



---
 rtl/bus_arbiter8.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter8.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one WIDTH-bit bus between 8 requesters; owner keeps the bus until it drops req.
// Optional ARB_TIMEOUT_EN: force release after HOLD_MAX owned cycles when another requester is waiting.
module bus_arbiter8 #(
  parameter int WIDTH    = 16,
  parameter int HOLD_MAX = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  output logic [7:0]       grant,
  output logic [2:0]       sel,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             dbg_state_o
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;

  logic [7:0] cand;
  logic       win_found;
  logic [2:0] winner;
  logic       at_limit;
  logic       keep;

  // The current owner is never a candidate, so a timed-out owner cannot re-win immediately.
  always_comb begin
    cand = req;
    if (state_q == OWNED) cand[sel_q] = 1'b0;
    win_found = |cand;
    winner    = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      if (cand[ptr_q + 3'(k)]) winner = ptr_q + 3'(k);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(HOLD_MAX) > 4) ? $clog2(HOLD_MAX) : 4;

  logic [CW-1:0] hold_q, hold_d;

  assign at_limit = (hold_q == CW'(HOLD_MAX - 1));

  // Counts owned cycles; clears on every new grant, and at the limit when nobody else waits.
  always_comb begin
    hold_d = '0;
    if (keep) hold_d = at_limit ? '0 : hold_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  logic unused_hold_max;

  assign at_limit        = 1'b0;
  assign unused_hold_max = (HOLD_MAX > 0);
`endif

  assign keep = (state_q == OWNED) && req[sel_q] && !(at_limit && win_found);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = 8'b1 << winner;
          sel_d   = winner;
          ptr_d   = winner + 3'd1;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!keep) begin
          if (win_found) begin
            grant_d = 8'b1 << winner;
            sel_d   = winner;
            ptr_d   = winner + 3'd1;
          end else begin
            grant_d = 8'h00;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = 8'h00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  logic [WIDTH-1:0] mux_out;

  always_comb begin
    mux_out = '0;
    case (sel_q)
      3'd0: mux_out = in0;
      3'd1: mux_out = in1;
      3'd2: mux_out = in2;
      3'd3: mux_out = in3;
      3'd4: mux_out = in4;
      3'd5: mux_out = in5;
      3'd6: mux_out = in6;
      3'd7: mux_out = in7;
      default: mux_out = '0;
    endcase
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign valid       = |grant_q;
  assign out         = valid ? mux_out : '0;
  assign dbg_state_o = (state_q == OWNED);

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: reset, single grant, wrap, round robin, reset mid-grant, hold/timeout.
module tb_bus_arbiter8;

  localparam int W  = 16;
  localparam int VW = 8 + 3 + 1 + W;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   req;
  logic [W-1:0] din [8];
  logic [7:0]   grant;
  logic [2:0]   sel;
  logic         valid;
  logic [W-1:0] out;
  logic         dbg_state;

  logic [VW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bus_arbiter8 #(.WIDTH(W), .HOLD_MAX(4)) dut (
    .clock(clock), .reset(reset), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .grant(grant), .sel(sel), .valid(valid), .out(out),
    .dbg_state_o(dbg_state)
  );

  function automatic logic [VW-1:0] ev(input logic [7:0] g, input logic [2:0] s,
                                       input logic v, input logic [W-1:0] o);
    return {g, s, v, o};
  endfunction

  task automatic compare_pop(input string tag);
    logic [VW-1:0] got, e;
    got = {grant, sel, valid, out};
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      vectors++;
      assert (got === e) else begin
        miscompares++;
        $error("FAIL %s: got grant=%h sel=%0d valid=%b out=%h, expected grant=%h sel=%0d valid=%b out=%h",
               tag, got[27:20], got[19:17], got[16], got[15:0], e[27:20], e[19:17], e[16], e[15:0]);
      end
    end
  endtask

  // Drive req, push the expected post-edge outputs, then check #1 after the edge.
  task automatic apply(input logic [7:0] r, input logic [VW-1:0] e, input string tag);
    req = r;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    compare_pop(tag);
  endtask

  task automatic check_now(input logic [VW-1:0] e, input string tag);
    exp_q.push_back(e);
    #1;
    compare_pop(tag);
  endtask

  initial begin
    din[0] = 16'h8000;
    for (int i = 1; i < 8; i++) din[i] = 16'(i);
    reset = 1'b1;
    req   = 8'hFF;

    apply(8'hFF, ev(8'h00, 3'd0, 1'b0, 16'h0000), "reset_c1");
    apply(8'hFF, ev(8'h00, 3'd0, 1'b0, 16'h0000), "reset_c2");
    reset = 1'b0;
    apply(8'h00, ev(8'h00, 3'd0, 1'b0, 16'h0000), "idle");

    apply(8'h04, ev(8'h04, 3'd2, 1'b1, 16'h0002), "single_grant");
    apply(8'h04, ev(8'h04, 3'd2, 1'b1, 16'h0002), "single_hold");
    din[2] = 16'hABCD;
    check_now(ev(8'h04, 3'd2, 1'b1, 16'hABCD), "comb_out");
    din[2] = 16'h0002;
    apply(8'h00, ev(8'h00, 3'd2, 1'b0, 16'h0000), "single_release");

    reset = 1'b1;
    apply(8'h00, ev(8'h00, 3'd0, 1'b0, 16'h0000), "reset_again");
    reset = 1'b0;
    apply(8'h81, ev(8'h01, 3'd0, 1'b1, 16'h8000), "simul_81");
    apply(8'h80, ev(8'h80, 3'd7, 1'b1, 16'h0007), "handoff_7");
    apply(8'h81, ev(8'h80, 3'd7, 1'b1, 16'h0007), "no_preempt");
    apply(8'h01, ev(8'h01, 3'd0, 1'b1, 16'h8000), "wrap_to_0");

    for (int i = 0; i < 8; i++) begin
      apply(8'hFF, ev(8'(1) << i, 3'(i), 1'b1, din[i]), "rr_hold");
      apply(~(8'(1) << i), ev(8'(1) << ((i + 1) % 8), 3'((i + 1) % 8), 1'b1, din[(i + 1) % 8]),
            "rr_next");
    end

    for (int i = 0; i < 3; i++) apply(8'hFF, ev(8'h01, 3'd0, 1'b1, din[0]), "hold_all_req");
    for (int i = 0; i < 6; i++) begin
      din[0] = 16'($urandom_range(0, 16'hFFFF));
      check_now(ev(8'h01, 3'd0, 1'b1, din[0]), "rand_data");
    end

    apply(8'h10, ev(8'h10, 3'd4, 1'b1, 16'h0004), "to_owner_4");
    apply(8'hFF, ev(8'h10, 3'd4, 1'b1, 16'h0004), "owner_4_hold");
    reset = 1'b1;
    apply(8'hFF, ev(8'h00, 3'd0, 1'b0, 16'h0000), "reset_mid_grant");
    reset = 1'b0;
    apply(8'hFF, ev(8'h01, 3'd0, 1'b1, din[0]), "after_reset_ptr0");
    apply(8'h00, ev(8'h00, 3'd0, 1'b0, 16'h0000), "release_all");

    reset = 1'b1;
    apply(8'h00, ev(8'h00, 3'd0, 1'b0, 16'h0000), "reset_pre_hold");
    reset = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) apply(8'h03, ev(8'h01, 3'd0, 1'b1, din[0]), "tmo_owner0");
    for (int i = 0; i < 4; i++) apply(8'h03, ev(8'h02, 3'd1, 1'b1, din[1]), "tmo_owner1");
    apply(8'h03, ev(8'h01, 3'd0, 1'b1, din[0]), "tmo_back_to_0");
    for (int i = 0; i < 10; i++) apply(8'h01, ev(8'h01, 3'd0, 1'b1, din[0]), "tmo_alone_hold");
`else
    for (int i = 0; i < 20; i++) apply(8'h03, ev(8'h01, 3'd0, 1'b1, din[0]), "no_timeout_hold");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
